data_memory: RTL and testbench



---
 rtl/data_memory.sv | 92 +++++++++
 tb/tb_data_memory.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// ---------------------------------------------------------------------------
// data_memory
//
// Word-organised data memory for the MEM stage of a single-cycle MIPS
// datapath. The ALU result is the word address and the rt register value is
// the store data. Loads are combinational from the storage array, so load data
// is valid in the same cycle as the address. Stores commit on the rising clock
// edge.
//
// Ports
//   CLK                   in   1           system clock, rising edge active
//   RST                   in   1           asynchronous active-high reset;
//                                          clears every word to 0
//   DM_Input_Address      in   ADDR_WIDTH  word index (not a byte address)
//   DM_Data_To_Write      in   DATA_WIDTH  store data
//   DM_Write_Enable_Flag  in   1           store enable (MemWrite)
//   DM_Output_Data        out  DATA_WIDTH  load data
//   DM_Addr_Error         out  1           only with DM_ADDR_CHECK_EN
//
// Build option
//   DM_ADDR_CHECK_EN  When defined, an address with any bit at or above
//                     INDEX_BITS set raises DM_Addr_Error, blocks the store
//                     and forces the load data to 0. When undefined, the upper
//                     address bits are ignored and addresses wrap modulo DEPTH.
// ---------------------------------------------------------------------------
module data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int INDEX_BITS = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] DM_Input_Address,
  input  logic [DATA_WIDTH-1:0] DM_Data_To_Write,
  input  logic                  DM_Write_Enable_Flag,
`ifdef DM_ADDR_CHECK_EN
  output logic                  DM_Addr_Error,
`endif
  output logic [DATA_WIDTH-1:0] DM_Output_Data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [INDEX_BITS-1:0] w_index;
  logic                  w_addr_upper;
  logic                  w_addr_err;
  logic                  w_wr_en;

  assign w_index = DM_Input_Address[INDEX_BITS-1:0];

  // Any set bit above the word index marks an out-of-range address.
  generate
    if (ADDR_WIDTH > INDEX_BITS) begin : g_upper
      assign w_addr_upper = |DM_Input_Address[ADDR_WIDTH-1:INDEX_BITS];
    end else begin : g_no_upper
      assign w_addr_upper = 1'b0;
    end
  endgenerate

`ifdef DM_ADDR_CHECK_EN
  // The error flag is held low while the memory is being cleared.
  assign w_addr_err    = w_addr_upper & ~RST;
  assign DM_Addr_Error = w_addr_err;
`else
  // Upper bits are deliberately ignored so the address wraps modulo DEPTH.
  assign w_addr_err = 1'b0 & w_addr_upper;
`endif

  assign w_wr_en = DM_Write_Enable_Flag & ~w_addr_err;

  // Storage. Reset clears every word at once; an X enable evaluates false in
  // the if-condition, so it never writes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[w_index] <= DM_Data_To_Write;
    end
  end

  // Combinational load path; a same-address store becomes visible right after
  // the edge because the output reads the array directly.
  always_comb begin
    DM_Output_Data = r_mem[w_index];
    if (w_addr_err) begin
      DM_Output_Data = '0;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  logic        CLK;
  logic        RST;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
`ifdef DM_ADDR_CHECK_EN
  logic        aerr;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] model [256];
  logic [31:0] exp_q [$];

  data_memory #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .DEPTH(256),
    .INDEX_BITS(8)
  ) dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .DM_Input_Address     (addr),
    .DM_Data_To_Write     (wdata),
    .DM_Write_Enable_Flag (we),
`ifdef DM_ADDR_CHECK_EN
    .DM_Addr_Error        (aerr),
`endif
    .DM_Output_Data       (rdata)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Expected load value for an address, from the bench's own memory model.
  function automatic logic [31:0] expected_for(input logic [31:0] a);
`ifdef DM_ADDR_CHECK_EN
    if (a[31:8] != 24'd0) return 32'd0;
`endif
    return model[a[7:0]];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model[i] = 32'd0;
  endtask

  // Pop the oldest expectation and compare against the current load data.
  task automatic check_out(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s scoreboard empty obs=%08h", tag, rdata);
      return;
    end
    e = exp_q.pop_front();
    total++;
    assert (rdata === e) else begin
      bad++;
      $error("FAIL %s obs=%08h exp=%08h", tag, rdata, e);
    end
  endtask

  // Drive a read address, queue its expectation, sample one step later.
  task automatic rd(input logic [31:0] a, input string tag);
    addr = a;
    exp_q.push_back(expected_for(a));
    #1;
    check_out(tag);
  endtask

  // Full store across one rising edge; the model follows the store rule.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge CLK);
`ifdef DM_ADDR_CHECK_EN
    if (a[31:8] == 24'd0) model[a[7:0]] = d;
`else
    model[a[7:0]] = d;
`endif
    #1;
    @(negedge CLK);
    we = 1'b0;
  endtask

  initial begin
    RST   = 1'b1;
    we    = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;
    clear_model();

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    rd(32'd0, "rst_hold_a0");
`ifdef DM_ADDR_CHECK_EN
    addr = 32'd260;
    #1;
    total++;
    assert (aerr === 1'b0) else begin
      bad++;
      $error("FAIL aerr_in_reset obs=%0b exp=0", aerr);
    end
`endif
    @(negedge CLK);
    RST = 1'b0;
    rd(32'd0, "post_rst_a0");
    rd(32'd1, "post_rst_a1");
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      rd(32'd1, "idle_a1");
    end

    // Store 7 at address 2; the output changes exactly at the edge
    @(negedge CLK);
    addr  = 32'd2;
    wdata = 32'd7;
    we    = 1'b1;
    rd(32'd2, "pre_edge_a2");
    @(posedge CLK);
    model[2] = 32'd7;
    rd(32'd2, "post_edge_a2");
    @(negedge CLK);
    we = 1'b0;
    rd(32'd2, "hold_a2");
    rd(32'd0, "other_a0");
    rd(32'd2, "again_a2");

    // Enable low over several edges must not store
    @(negedge CLK);
    wdata = 32'hDEADBEEF;
    addr  = 32'd2;
    repeat (3) @(posedge CLK);
    #1;
    rd(32'd2, "we0_a2");

    // Unknown enable counts as no store
    @(negedge CLK);
    we    = 1'bx;
    wdata = 32'h5555AAAA;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    we = 1'b0;
    rd(32'd2, "wex_a2");

    // Back-to-back stores, then reset between edges with no clock edge
    wr(32'd3, 32'hA5A5A5A5);
    @(negedge CLK);
    addr  = 32'd255;
    wdata = 32'h12345678;
    we    = 1'b1;
    @(posedge CLK);
    model[255] = 32'h12345678;
    #1;
    @(negedge CLK);
    we = 1'b0;
    rd(32'd3,   "rb_a3");
    rd(32'd255, "rb_a255");
    rd(32'd2,   "rb_a2");
    @(posedge CLK);
    #1;
    RST = 1'b1;
    clear_model();
    rd(32'd3,   "async_rst_a3");
    rd(32'd255, "async_rst_a255");
    rd(32'd2,   "async_rst_a2");

    // Stores are blocked while reset is held
    @(negedge CLK);
    addr  = 32'd5;
    wdata = 32'h0BADF00D;
    we    = 1'b1;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    we = 1'b0;
    rd(32'd5, "wr_in_rst_a5");

    // First store right after release
    RST = 1'b0;
    wr(32'd6, 32'h00000066);
    rd(32'd6, "first_after_rst_a6");

    // Out-of-range address 256+4
    wr(32'd260, 32'd9);
`ifdef DM_ADDR_CHECK_EN
    addr = 32'd260;
    #1;
    total++;
    assert (aerr === 1'b1) else begin
      bad++;
      $error("FAIL aerr_260 obs=%0b exp=1", aerr);
    end
    rd(32'd260, "oor_out_260");
    rd(32'd4,   "oor_no_store_a4");
    addr = 32'd4;
    #1;
    total++;
    assert (aerr === 1'b0) else begin
      bad++;
      $error("FAIL aerr_4 obs=%0b exp=0", aerr);
    end
`else
    rd(32'd4,           "wrap_a4");
    rd(32'd260,         "wrap_a260");
    rd(32'h8000_0004,   "wrap_hi_a4");
`endif
    rd(32'd6, "final_a6");

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_leftover obs=%0d exp=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
